ccd_pattern_gen: RTL and testbench

Synthetic CCD sensor source that drives the same FVAL/LVAL/10-bit DATA raster interface the capture stage consumes. It replaces the camera head for bring-up and regression of the capture, Bayer and display pipeline. It produces framed, line-blanked test patterns with run control and a frame counter. All outputs are registered and phase-aligned, so a downstream capture stage sees exactly what a sensor would present.

---
 rtl/ccd_pattern_gen.sv | 205 ++++++++++++++++++++
 tb/tb_ccd_pattern_gen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccd_pattern_gen.sv
// ccd_pattern_gen
// Synthetic CCD raster source. Emits FVAL/LVAL-framed 10-bit test patterns
// with the same timing a sensor head presents to the capture stage.
//
// Ports
//   iCLK         pixel clock
//   iRST         asynchronous active-low reset
//   iSTART       sets the run flag (level or pulse)
//   iEND         clears the run flag (wins over iSTART)
//   iPATTERN     pattern select, latched when a frame starts
//   oFVAL        frame valid
//   oLVAL        line valid
//   oDATA        pixel data, 0 outside oLVAL
//   oX_Cont      column of the pixel on oDATA, 0 outside oLVAL
//   oY_Cont      line index within the frame, 0 outside oFVAL
//   oFrame_Cont  frames started since reset (wraps)
//   oBUSY        high whenever the sequencer is not idle
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | stopped, all raster outputs 0
// VBLK  | vertical blanking, FVAL low for V_BLANK cycles
// LEAD  | FVAL high, LVAL low for H_BLANK cycles before line 0
// ACT   | active pixels, LVAL high for H_ACTIVE cycles
// HBLK  | line blanking, LVAL low for H_BLANK cycles after each line

module ccd_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 1024,
    parameter int H_BLANK  = 64,
    parameter int V_BLANK  = 256
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iEND,
    input  logic [1:0]  iPATTERN,
    output logic        oFVAL,
    output logic        oLVAL,
    output logic [9:0]  oDATA,
    output logic [10:0] oX_Cont,
    output logic [10:0] oY_Cont,
    output logic [31:0] oFrame_Cont,
    output logic        oBUSY
);

    localparam logic [10:0] H_LAST  = 11'(H_ACTIVE - 1);
    localparam logic [10:0] V_LAST  = 11'(V_ACTIVE - 1);
    localparam logic [15:0] HB_LOAD = 16'(H_BLANK - 1);
    localparam logic [15:0] VB_LOAD = 16'(V_BLANK - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VBLK,
        S_LEAD,
        S_ACT,
        S_HBLK
    } state_t;

    state_t       state_q;
    logic         run_q;
    logic         first_q;
    logic [15:0]  blk_cnt_q;
    logic [1:0]   pat_q;
    logic         fval_q;
    logic         lval_q;
    logic [9:0]   data_q;
    logic [10:0]  x_q;
    logic [10:0]  y_q;
    logic [31:0]  frame_cnt_q;
    logic         busy_q;
    logic [31:0]  frame_cnt_d;

    assign oFVAL       = fval_q;
    assign oLVAL       = lval_q;
    assign oDATA       = data_q;
    assign oX_Cont     = x_q;
    assign oY_Cont     = y_q;
    assign oFrame_Cont = frame_cnt_q;
    assign oBUSY       = busy_q;

    assign frame_cnt_d = frame_cnt_q + 32'd1;

    function automatic logic [9:0] pix(input logic [1:0]  sel,
                                       input logic [10:0] x,
                                       input logic [10:0] y,
                                       input logic [31:0] fc);
        logic [9:0] v;
        case (sel)
            2'd0:    v = x[9:0];
            2'd1:    v = y[9:0];
            2'd2:    v = (x[6] ^ y[6]) ? 10'h3FF : 10'h000;
            default: v = x[9:0] + y[9:0] + fc[9:0];
        endcase
        return v;
    endfunction

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            run_q <= 1'b0;
        end else if (iEND) begin
            run_q <= 1'b0;
        end else if (iSTART) begin
            run_q <= 1'b1;
        end
    end

    // first_q marks the VBLK entered straight from IDLE: a start request
    // always yields at least one frame, even if iEND follows before the
    // blanking ends. Later VBLKs consult the run flag.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q     <= S_IDLE;
            first_q     <= 1'b0;
            blk_cnt_q   <= 16'd0;
            pat_q       <= 2'd0;
            fval_q      <= 1'b0;
            lval_q      <= 1'b0;
            data_q      <= 10'd0;
            x_q         <= 11'd0;
            y_q         <= 11'd0;
            frame_cnt_q <= 32'd0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    fval_q <= 1'b0;
                    lval_q <= 1'b0;
                    data_q <= 10'd0;
                    x_q    <= 11'd0;
                    y_q    <= 11'd0;
                    if (run_q) begin
                        state_q   <= S_VBLK;
                        blk_cnt_q <= VB_LOAD;
                        first_q   <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_VBLK: begin
                    if (blk_cnt_q == 16'd0) begin
                        if (run_q || first_q) begin
                            state_q     <= S_LEAD;
                            fval_q      <= 1'b1;
                            pat_q       <= iPATTERN;
                            frame_cnt_q <= frame_cnt_d;
                            blk_cnt_q   <= HB_LOAD;
                            first_q     <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        blk_cnt_q <= blk_cnt_q - 16'd1;
                    end
                end
                S_LEAD: begin
                    if (blk_cnt_q == 16'd0) begin
                        state_q <= S_ACT;
                        lval_q  <= 1'b1;
                        x_q     <= 11'd0;
                        y_q     <= 11'd0;
                        data_q  <= pix(pat_q, 11'd0, 11'd0, frame_cnt_q);
                    end else begin
                        blk_cnt_q <= blk_cnt_q - 16'd1;
                    end
                end
                S_ACT: begin
                    if (x_q == H_LAST) begin
                        state_q   <= S_HBLK;
                        lval_q    <= 1'b0;
                        x_q       <= 11'd0;
                        data_q    <= 10'd0;
                        blk_cnt_q <= HB_LOAD;
                    end else begin
                        x_q    <= x_q + 11'd1;
                        data_q <= pix(pat_q, x_q + 11'd1, y_q, frame_cnt_q);
                    end
                end
                S_HBLK: begin
                    if (blk_cnt_q == 16'd0) begin
                        if (y_q == V_LAST) begin
                            state_q   <= S_VBLK;
                            fval_q    <= 1'b0;
                            y_q       <= 11'd0;
                            blk_cnt_q <= VB_LOAD;
                        end else begin
                            state_q <= S_ACT;
                            lval_q  <= 1'b1;
                            x_q     <= 11'd0;
                            y_q     <= y_q + 11'd1;
                            data_q  <= pix(pat_q, 11'd0, y_q + 11'd1, frame_cnt_q);
                        end
                    end else begin
                        blk_cnt_q <= blk_cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccd_pattern_gen.sv
module tb_ccd_pattern_gen;

    localparam int HA     = 8;
    localparam int VA     = 4;
    localparam int HB     = 3;
    localparam int VB     = 5;
    localparam int LP     = HA + HB;
    localparam int FV     = HB + VA * LP;
    localparam int PERIOD = VB + FV;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iSTART = 1'b0;
    logic        iEND = 1'b0;
    logic [1:0]  iPATTERN = 2'd0;
    logic        oFVAL;
    logic        oLVAL;
    logic [9:0]  oDATA;
    logic [10:0] oX_Cont;
    logic [10:0] oY_Cont;
    logic [31:0] oFrame_Cont;
    logic        oBUSY;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    ccd_pattern_gen #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iEND(iEND),
        .iPATTERN(iPATTERN), .oFVAL(oFVAL), .oLVAL(oLVAL), .oDATA(oDATA),
        .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oFrame_Cont(oFrame_Cont),
        .oBUSY(oBUSY)
    );

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    // Model: a frame is a timeline position p counted from VBLK entry;
    // raster outputs follow from p by arithmetic.
    bit         m_run = 1'b0;
    bit         m_busy = 1'b0;
    bit         m_first = 1'b0;
    int         m_p = 0;
    logic [31:0] m_fc = 32'd0;
    logic [1:0] m_pat = 2'd0;

    always @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            m_run   <= 1'b0;
            m_busy  <= 1'b0;
            m_first <= 1'b0;
            m_p     <= 0;
            m_fc    <= 32'd0;
            m_pat   <= 2'd0;
        end else begin
            if (!m_busy) begin
                if (m_run) begin
                    m_busy  <= 1'b1;
                    m_p     <= 0;
                    m_first <= 1'b1;
                end
            end else if (m_p == VB - 1) begin
                if (m_run || m_first) begin
                    m_p     <= VB;
                    m_fc    <= m_fc + 32'd1;
                    m_pat   <= iPATTERN;
                    m_first <= 1'b0;
                end else begin
                    m_busy <= 1'b0;
                end
            end else if (m_p == PERIOD - 1) begin
                m_p <= 0;
            end else begin
                m_p <= m_p + 1;
            end
            if (iEND) m_run <= 1'b0;
            else if (iSTART) m_run <= 1'b1;
        end
    end

    function automatic logic [9:0] pat_val(input logic [1:0] s, input int x,
                                           input int y, input logic [31:0] fc);
        int v;
        case (s)
            2'd0: v = x % 1024;
            2'd1: v = y % 1024;
            2'd2: v = (((x / 64) + (y / 64)) % 2 == 1) ? 1023 : 0;
            default: v = (x + y + int'(fc % 1024)) % 1024;
        endcase
        return 10'(v);
    endfunction

    always @(negedge iCLK) begin
        logic        e_fval, e_lval;
        logic [9:0]  e_data;
        logic [10:0] e_x, e_y;
        int q, r;
        e_fval = 1'b0; e_lval = 1'b0; e_data = 10'd0; e_x = 11'd0; e_y = 11'd0;
        if (m_busy && m_p >= VB) begin
            q = m_p - VB;
            e_fval = 1'b1;
            if (q >= HB) begin
                r = q - HB;
                e_y = 11'(r / LP);
                if (r % LP < HA) begin
                    e_lval = 1'b1;
                    e_x    = 11'(r % LP);
                    e_data = pat_val(m_pat, r % LP, r / LP, m_fc);
                end
            end
        end
        checks++;
        if ({oFVAL, oLVAL, oDATA, oX_Cont, oY_Cont, oFrame_Cont, oBUSY} !==
            {e_fval, e_lval, e_data, e_x, e_y, m_fc, m_busy}) begin
            errors++;
            $display("FAIL model_cycle cyc=%0d got fval=%b lval=%b data=%0d x=%0d y=%0d fc=%0d busy=%b expected fval=%b lval=%b data=%0d x=%0d y=%0d fc=%0d busy=%b",
                     cyc, oFVAL, oLVAL, oDATA, oX_Cont, oY_Cont, oFrame_Cont, oBUSY,
                     e_fval, e_lval, e_data, e_x, e_y, m_fc, m_busy);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_fval_rise(output bit ok);
        int n;
        n = 0;
        while (oFVAL && n < 4 * PERIOD) begin @(negedge iCLK); n++; end
        while (!oFVAL && n < 4 * PERIOD) begin @(negedge iCLK); n++; end
        ok = oFVAL;
        chk("fval_rise_in_time", longint'(ok), 1);
    endtask

    task automatic wait_pix(input int y, input int x, input int fc, output bit ok);
        int n;
        n = 0;
        while (!(oLVAL && oY_Cont == 11'(y) && oX_Cont == 11'(x) && oFrame_Cont == 32'(fc))
               && n < 4 * PERIOD) begin
            @(negedge iCLK); n++;
        end
        ok = oLVAL && oY_Cont == 11'(y) && oX_Cont == 11'(x) && oFrame_Cont == 32'(fc);
        chk("pixel_reached", longint'(ok), 1);
    endtask

    initial begin
        bit ok;
        int k, rise1, rise2, hi, cur, bursts, bad, fvh, bsy, fc0, n;

        #1 iRST = 1'b0;
        repeat (3) @(negedge iCLK);
        chk("reset_fval", longint'(oFVAL), 0);
        chk("reset_busy", longint'(oBUSY), 0);
        chk("reset_fc", longint'(oFrame_Cont), 0);
        iRST = 1'b1;
        repeat (5) @(negedge iCLK);

        // Single frame: start then end two edges later.
        iPATTERN = 2'd0;
        iSTART = 1'b1; k = cyc + 1;
        @(negedge iCLK); iSTART = 1'b0;
        @(negedge iCLK); iEND = 1'b1;
        @(negedge iCLK); iEND = 1'b0;
        wait_fval_rise(ok);
        rise1 = cyc;
        chk("start_to_fval_latency", rise1 - k, 1 + VB);
        hi = 0; cur = 0; bursts = 0; bad = 0;
        while (oFVAL && hi < 1000) begin
            hi++;
            if (oLVAL) cur++;
            else if (cur != 0) begin
                if (cur != HA) bad++;
                bursts++; cur = 0;
            end
            @(negedge iCLK);
        end
        if (cur != 0) begin bursts++; if (cur != HA) bad++; end
        chk("fval_high_len", hi, 47);
        chk("lval_bursts", bursts, 4);
        chk("lval_bad_bursts", bad, 0);
        repeat (VB + 2) @(negedge iCLK);
        chk("single_idle_busy", longint'(oBUSY), 0);
        chk("single_frame_cnt", longint'(oFrame_Cont), 1);

        // Continuous pattern 0, switched to pattern 1 mid-frame.
        iSTART = 1'b1;
        @(negedge iCLK); iSTART = 1'b0;
        wait_fval_rise(ok);
        rise1 = cyc; fc0 = int'(oFrame_Cont);
        chk("cont_first_fc", fc0, 2);
        wait_pix(1, 0, fc0, ok);
        iPATTERN = 2'd1;
        wait_pix(3, 4, fc0, ok);
        chk("ramp_kept_mid_frame", longint'(oDATA), 4);
        wait_fval_rise(ok);
        rise2 = cyc;
        chk("frame_period", rise2 - rise1, 52);
        chk("fc_step", longint'(oFrame_Cont) - fc0, 1);
        wait_pix(1, 6, fc0 + 1, ok);
        chk("pat1_line1", longint'(oDATA), 1);
        wait_pix(3, 0, fc0 + 1, ok);
        chk("pat1_line3", longint'(oDATA), 3);
        iEND = 1'b1;
        @(negedge iCLK); iEND = 1'b0;
        n = 0;
        while (oBUSY && n < 2 * PERIOD + 10) begin @(negedge iCLK); n++; end
        chk("stop_to_idle", longint'(oBUSY), 0);

        // Simultaneous start and end while idle.
        iSTART = 1'b1; iEND = 1'b1;
        @(negedge iCLK); iSTART = 1'b0; iEND = 1'b0;
        fvh = 0; bsy = 0;
        repeat (100) begin
            @(negedge iCLK);
            if (oFVAL) fvh++;
            if (oBUSY) bsy++;
        end
        chk("both_fval_cycles", fvh, 0);
        chk("both_busy_cycles", bsy, 0);

        // Reset during line 2 active.
        iSTART = 1'b1;
        @(negedge iCLK); iSTART = 1'b0;
        n = 0;
        while (!(oLVAL && oY_Cont == 11'd2) && n < 4 * PERIOD) begin @(negedge iCLK); n++; end
        chk("reached_line2", longint'(oLVAL && oY_Cont == 11'd2), 1);
        #2 iRST = 1'b0;
        #1;
        chk("rst_fval", longint'(oFVAL), 0);
        chk("rst_lval", longint'(oLVAL), 0);
        chk("rst_data", longint'(oDATA), 0);
        chk("rst_x", longint'(oX_Cont), 0);
        chk("rst_y", longint'(oY_Cont), 0);
        chk("rst_fc", longint'(oFrame_Cont), 0);
        chk("rst_busy", longint'(oBUSY), 0);
        repeat (2) @(negedge iCLK);
        iRST = 1'b1;
        fvh = 0; bsy = 0;
        repeat (20) begin
            @(negedge iCLK);
            if (oFVAL) fvh++;
            if (oBUSY) bsy++;
        end
        chk("post_rst_fval_cycles", fvh, 0);
        chk("post_rst_busy_cycles", bsy, 0);

        // Fresh start with pattern 3 across two frames.
        iPATTERN = 2'd3;
        iSTART = 1'b1;
        @(negedge iCLK); iSTART = 1'b0;
        n = 0;
        while (!oLVAL && n < 2 * PERIOD) begin @(negedge iCLK); n++; end
        chk("restart_first_y", longint'(oY_Cont), 0);
        chk("restart_first_x", longint'(oX_Cont), 0);
        chk("restart_fc", longint'(oFrame_Cont), 1);
        chk("restart_first_data", longint'(oDATA), 1);
        wait_pix(2, 5, 1, ok);
        chk("pat3_frame1", longint'(oDATA), 8);
        wait_pix(2, 5, 2, ok);
        chk("pat3_frame2", longint'(oDATA), 9);
        iEND = 1'b1;
        @(negedge iCLK); iEND = 1'b0;
        repeat (3) @(negedge iCLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
